usb_in_ep_arbiter: RTL and testbench
====================================

Name: usb_in_ep_arbiter

Overview:
Round-robin arbiter that shares the single USB IN endpoint packet buffer among NUM_EP IN-endpoint clients, such as the control endpoint and bulk/serial endpoints.
- Each client uses the same req/grant/data_put/data_done/stall handshake the control endpoint already drives.
- The arbiter locks the buffer to one owner from first request until the protocol engine reports the packet sent.
- It muxes the owner's write strobes and data onto the buffer port.
- It sits between the endpoint clients and the IN packet buffer / protocol engine.

Parameters:
- NUM_EP, 4, number of IN endpoint clients (2..8); client 0 is the control endpoint.
- TIMEOUT_CYCLES, 4096, idle-put cycles before a hung owner is revoked (used only with the optional feature).

Ports:
- clk  in  1  system clock (48 MHz domain).
- reset_n  in  1  asynchronous active-low reset.
- ep_req  in  NUM_EP  per-client request for the buffer.
- ep_grant  out  NUM_EP  one-hot registered grant.
- ep_data_put  in  NUM_EP  per-client byte write strobe.
- ep_data  in  8*NUM_EP  per-client byte; client i occupies bits [8i+7:8i].
- ep_data_done  in  NUM_EP  per-client end-of-packet pulse.
- ep_stall  in  NUM_EP  per-client stall pulse.
- buf_data_free  in  1  buffer can accept a byte.
- buf_pkt_sent  in  1  one-cycle pulse: packet ACKed by host or flushed.
- buf_data_put  out  1  muxed write strobe to buffer.
- buf_data  out  8  muxed byte.
- buf_data_done  out  1  muxed end-of-packet.
- buf_stall  out  1  muxed stall.
- buf_owner  out  3  index of current/last owner.
- busy  out  1  high in GRANT or WAIT_SENT.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low (reset_n). Asserting reset_n low clears all state immediately, even mid-packet.
- Reset values:
  - state IDLE
  - ep_grant 0
  - rr_ptr NUM_EP-1, so client 0 wins first
  - buf_owner 0
  - busy 0
  - mux outputs 0
  - timeout counter 0
- States:
  - IDLE: if any ep_req, pick the winner: first requester scanning from rr_ptr+1 modulo NUM_EP. Register ep_grant[winner]=1, buf_owner=winner, go to GRANT. Grant appears one cycle after req is sampled.
  - GRANT: buffer is owned.
    - ep_data_done or ep_stall from owner -> WAIT_SENT. Grant stays asserted.
    - Owner drops ep_req without done or stall -> abandon: drop grant, rr_ptr=owner, go to IDLE.
    - Done/stall and req-drop in the same cycle -> WAIT_SENT (done wins).
  - WAIT_SENT: grant held, owner's further puts ignored (buf_data_put forced 0). On buf_pkt_sent: drop grant, rr_ptr=owner, go to IDLE.
- buf_pkt_sent outside WAIT_SENT is ignored.
- Minimum gap between owners: one IDLE cycle. Back-to-back requests from the same client are allowed, but other requesters win first under round-robin.
- Datapath mux (combinational from registered grant):
  - buf_data_put = ep_data_put[owner] & buf_data_free & state==GRANT.
  - buf_data = ep_data[owner] while granted, else 0.
  - buf_data_done = ep_data_done[owner] while granted, else 0.
  - buf_stall = ep_stall[owner] while granted, else 0.
  - Non-owner strobes are discarded.
- ep_grant is always one-hot or zero. Verification asserts this on every cycle.
- Requests from indices >= NUM_EP do not exist (width-bounded). rr_ptr wraps NUM_EP-1 -> 0.

Optional Feature:
- Macro USB_IN_ARB_TIMEOUT_EN.
- Defined:
  - A 13-bit counter clears on entry to GRANT and on every owner ep_data_put, and increments otherwise in GRANT.
  - On reaching TIMEOUT_CYCLES: force buf_data_done for one cycle, then go to WAIT_SENT.
  - Status output timeout_evt (1 bit) pulses for one cycle. It is held at 0 when the macro is undefined.
- Undefined: no counter; an owner may hold GRANT indefinitely.

Decomposition:
- Shared package/include usb_arb_defs: state encodings ARB_IDLE=0, ARB_GRANT=1, ARB_WAIT_SENT=2; the owner-index width constant; the default TIMEOUT_CYCLES.
- One sub-module: usb_rr_picker. It is purely combinational and maps (req vector, rr_ptr) to (valid, winner index).
- The FSM, counters and mux stay in the top.

Test Plan:
- Reset release with ep_req=4'b0001 -> ep_grant=4'b0001 after 1 cycle. Eight puts of 0x11..0x18 appear on buf_data. done -> WAIT_SENT. buf_pkt_sent -> grant 0, busy 0.
- ep_req=4'b1111 held, each client sends 1 byte + done, buf_pkt_sent 2 cycles later -> owner sequence 0,1,2,3,0 with exactly one IDLE cycle between grants.
- Client 2 owns; client 1 asserts data_put 0xAA -> buf_data_put stays 0 and buf_data carries only client 2's bytes.
- Owner 1 drops req mid-packet with no done -> grant drops next cycle, no buf_data_done, next winner is 2 when ep_req=4'b0101.
- reset_n pulsed low mid-GRANT -> ep_grant=0 in the same cycle (asynchronous). After release, ep_req=4'b1000 grants client 3.
- With USB_IN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner granted and silent -> timeout_evt and buf_data_done on cycle 16, then WAIT_SENT. Without the macro, the grant persists for 100 cycles.

Source files
------------

// File: rtl/usb_arb_defs.sv
// Shared definitions for the USB IN endpoint buffer arbiter: FSM encodings,
// owner index width and timeout defaults.
package usb_arb_defs;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_GRANT     = 2'd1,
        ARB_WAIT_SENT = 2'd2
    } arb_state_e;

    localparam int unsigned OWNER_W            = 3;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned TMR_W              = 13;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/usb_in_ep_arbiter_if.sv
// Client-side handshake and IN packet buffer port bundle for the IN endpoint arbiter.
interface usb_in_ep_arbiter_if #(
    parameter int unsigned NUM_EP = 4
);
    logic [NUM_EP-1:0]   ep_req;
    logic [NUM_EP-1:0]   ep_grant;
    logic [NUM_EP-1:0]   ep_data_put;
    logic [8*NUM_EP-1:0] ep_data;
    logic [NUM_EP-1:0]   ep_data_done;
    logic [NUM_EP-1:0]   ep_stall;
    logic                buf_data_free;
    logic                buf_pkt_sent;
    logic                buf_data_put;
    logic [7:0]          buf_data;
    logic                buf_data_done;
    logic                buf_stall;

    // Arbiter side
    modport master (
        input  ep_req, ep_data_put, ep_data, ep_data_done, ep_stall,
        input  buf_data_free, buf_pkt_sent,
        output ep_grant, buf_data_put, buf_data, buf_data_done, buf_stall
    );

    // Endpoint clients and packet buffer side
    modport slave (
        output ep_req, ep_data_put, ep_data, ep_data_done, ep_stall,
        output buf_data_free, buf_pkt_sent,
        input  ep_grant, buf_data_put, buf_data, buf_data_done, buf_stall
    );
endinterface

// File: rtl/usb_rr_picker.sv
// Combinational round-robin picker: first requester scanning upward from rr_ptr+1,
// wrapping at NUM_EP, with rr_ptr itself considered last.
module usb_rr_picker
    import usb_arb_defs::*;
#(
    parameter int unsigned NUM_EP = 4
) (
    input  logic [NUM_EP-1:0]  req,
    input  logic [OWNER_W-1:0] rr_ptr,
    output logic               valid_c,
    output logic [OWNER_W-1:0] winner_c
);

    function automatic logic [OWNER_W-1:0] wrap_add(input logic [OWNER_W-1:0] base,
                                                    input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_EP) sum = sum - NUM_EP;
        return OWNER_W'(sum);
    endfunction

    logic [OWNER_W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester overwrites last
    always_comb begin
        valid_c  = 1'b0;
        winner_c = '0;
        idx      = '0;
        for (int unsigned k = NUM_EP; k > 0; k--) begin
            idx = wrap_add(rr_ptr, k);
            if (req[idx]) begin
                valid_c  = 1'b1;
                winner_c = idx;
            end
        end
    end

endmodule

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin owner lock and datapath mux sharing the USB IN packet buffer among NUM_EP clients.
// Optional hung-owner revocation is built when USB_IN_ARB_TIMEOUT_EN is defined.
module usb_in_ep_arbiter
    import usb_arb_defs::*;
#(
    parameter int unsigned NUM_EP         = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    usb_in_ep_arbiter_if.master bus,
    output logic [OWNER_W-1:0]  buf_owner,
    output logic                busy,
    output logic                timeout_evt
);

    arb_state_e         state_q, state_d;
    logic [NUM_EP-1:0]  grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_q, rr_d;
    logic               busy_q, busy_d;
    logic               evt_q, evt_d;

    logic               pick_valid_c;
    logic [OWNER_W-1:0] pick_winner_c;
    logic               tout_hit_c;

    logic               own_req, own_put, own_done, own_stall, granted;
    logic [BYTE_W-1:0]  own_byte;

    usb_rr_picker #(.NUM_EP(NUM_EP)) u_picker (
        .req      (bus.ep_req),
        .rr_ptr   (rr_q),
        .valid_c  (pick_valid_c),
        .winner_c (pick_winner_c)
    );

    // Current owner's view of the client handshake
    always_comb begin
        own_req   = bus.ep_req[owner_q];
        own_put   = bus.ep_data_put[owner_q];
        own_done  = bus.ep_data_done[owner_q];
        own_stall = bus.ep_stall[owner_q];
        own_byte  = bus.ep_data[BYTE_W*32'(owner_q) +: BYTE_W];
        granted   = (state_q != ARB_IDLE);
    end

`ifdef USB_IN_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Idle-put counter: zero outside GRANT, cleared by any owner put
    assign tout_hit_c = (state_q == ARB_GRANT) && !own_put &&
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmr_d = '0;
        if ((state_q == ARB_GRANT) && !own_put && !tout_hit_c) tmr_d = tmr_q + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmr_q <= '0;
        else          tmr_q <= tmr_d;
    end
`else
    logic unused_timeout_cfg;

    assign tout_hit_c         = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state: done/stall beats req-drop, req-drop beats timeout
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        evt_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ARB_GRANT;
                    grant_d = NUM_EP'(1) << pick_winner_c;
                    owner_d = pick_winner_c;
                end
            end
            ARB_GRANT: begin
                if (own_done || own_stall) begin
                    state_d = ARB_WAIT_SENT;
                end else if (!own_req) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    rr_d    = owner_q;
                end else if (tout_hit_c) begin
                    state_d = ARB_WAIT_SENT;
                    evt_d   = 1'b1;
                end
            end
            ARB_WAIT_SENT: begin
                if (bus.buf_pkt_sent) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    rr_d    = owner_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= OWNER_W'(NUM_EP - 1);
            busy_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            evt_q   <= evt_d;
        end
    end

    // Owner-only datapath; a timeout forces end-of-packet in the first WAIT_SENT cycle
    assign bus.buf_data_put  = own_put & bus.buf_data_free & (state_q == ARB_GRANT);
    assign bus.buf_data      = granted ? own_byte : '0;
    assign bus.buf_data_done = granted & (own_done | evt_q);
    assign bus.buf_stall     = granted & own_stall;

    assign bus.ep_grant = grant_q;
    assign buf_owner    = owner_q;
    assign busy         = busy_q;
    assign timeout_evt  = evt_q;

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed, table-driven bench for usb_in_ep_arbiter with hand-written hold/timeout sequences.
module tb_usb_in_ep_arbiter;
    import usb_arb_defs::*;

    localparam int unsigned NUM_EP = 4;
    localparam int unsigned TOUT   = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [OWNER_W-1:0] buf_owner;
    logic               busy;
    logic               timeout_evt;

    usb_in_ep_arbiter_if #(.NUM_EP(NUM_EP)) bus ();

    usb_in_ep_arbiter #(.NUM_EP(NUM_EP), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .buf_owner   (buf_owner),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  req, put, done, stall;
        logic [31:0] data;
        logic        free, sent;
        logic [3:0]  grant;
        logic [2:0]  owner;
        logic        busy, bput;
        logic [7:0]  bdata;
        logic        bdone, bstall;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [31:0] bt(input int unsigned i, input logic [7:0] b);
        return 32'(b) << (8 * i);
    endfunction

    function automatic void add(input string n, input logic r,
                                input logic [3:0] rq, input logic [3:0] pt,
                                input logic [3:0] dn, input logic [3:0] st,
                                input logic [31:0] d, input logic fr, input logic sn,
                                input logic [3:0] g, input logic [2:0] o, input logic b,
                                input logic bp, input logic [7:0] bd,
                                input logic bdn, input logic bst);
        vec_t v;
        v.name = n;  v.rst_n = r;  v.req = rq;  v.put = pt;  v.done = dn;  v.stall = st;
        v.data = d;  v.free = fr;  v.sent = sn;
        v.grant = g; v.owner = o;  v.busy = b;  v.bput = bp; v.bdata = bd;
        v.bdone = bdn; v.bstall = bst;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_onehot(input string nm);
        check({nm, ".onehot"}, 32'($onehot0(bus.ep_grant)), 32'd1);
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] pt, input logic [3:0] dn,
                         input logic [3:0] st, input logic [31:0] d, input logic fr,
                         input logic sn);
        bus.ep_req = rq;  bus.ep_data_put = pt;  bus.ep_data_done = dn;  bus.ep_stall = st;
        bus.ep_data = d;  bus.buf_data_free = fr; bus.buf_pkt_sent = sn;
    endtask

    // One vector per cycle: drive, settle, compare, then advance past the next edge
    task automatic apply(input vec_t v);
        reset_n = v.rst_n;
        drive(v.req, v.put, v.done, v.stall, v.data, v.free, v.sent);
        #1;
        check({v.name, ".grant"},  32'(bus.ep_grant),      32'(v.grant));
        check({v.name, ".owner"},  32'(buf_owner),         32'(v.owner));
        check({v.name, ".busy"},   32'(busy),              32'(v.busy));
        check({v.name, ".bput"},   32'(bus.buf_data_put),  32'(v.bput));
        check({v.name, ".bdata"},  32'(bus.buf_data),      32'(v.bdata));
        check({v.name, ".bdone"},  32'(bus.buf_data_done), 32'(v.bdone));
        check({v.name, ".bstall"}, 32'(bus.buf_stall),     32'(v.bstall));
        check_onehot(v.name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rr_word;
        int unsigned w, prev;
        rr_word = 32'hA3A2_A1A0;

        // Reset release, eight bytes from client 0, done, sent
        add("rst", 0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0,  4'h0, 0, 0, 0, 8'h00, 0, 0);
        add("req0", 1, 4'h1, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            add("put0", 1, 4'h1, 4'h1, 4'h0, 4'h0, bt(0, 8'(8'h11 + i)), 1, 0,
                4'h1, 0, 1, 1, 8'(8'h11 + i), 0, 0);
        add("nofree", 1, 4'h1, 4'h1, 4'h0, 4'h0, 32'h19, 0, 0, 4'h1, 0, 1, 0, 8'h19, 0, 0);
        add("done0", 1, 4'h1, 4'h0, 4'h1, 4'h0, 32'h0, 1, 0,  4'h1, 0, 1, 0, 8'h00, 1, 0);
        add("wait_put", 1, 4'h1, 4'h1, 4'h0, 4'h0, 32'h99, 1, 0, 4'h1, 0, 1, 0, 8'h99, 0, 0);
        add("sent0", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 1,  4'h1, 0, 1, 0, 8'h00, 0, 0);
        add("idle0", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0,  4'h0, 0, 0, 0, 8'h00, 0, 0);

        // All four requesting: owners 0,1,2,3,0 with one IDLE cycle between
        add("rst2", 0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0,  4'h0, 0, 0, 0, 8'h00, 0, 0);
        for (int n = 0; n < 5; n++) begin
            w    = n % 4;
            prev = (n == 0) ? 0 : (n - 1) % 4;
            add("rr_idle", 1, 4'hF, 4'h0, 4'h0, 4'h0, rr_word, 1, 0, 4'h0, 3'(prev), 0, 0, 8'h00, 0, 0);
            add("rr_put",  1, 4'hF, 4'hF, 4'h0, 4'h0, rr_word, 1, 0, 4'(1 << w), 3'(w), 1, 1, 8'(8'hA0 + w), 0, 0);
            add("rr_done", 1, 4'hF, 4'h0, 4'hF, 4'h0, rr_word, 1, 0, 4'(1 << w), 3'(w), 1, 0, 8'(8'hA0 + w), 1, 0);
            add("rr_wait", 1, 4'hF, 4'h0, 4'h0, 4'h0, rr_word, 1, 0, 4'(1 << w), 3'(w), 1, 0, 8'(8'hA0 + w), 0, 0);
            add("rr_sent", 1, 4'hF, 4'h0, 4'h0, 4'h0, rr_word, 1, 1, 4'(1 << w), 3'(w), 1, 0, 8'(8'hA0 + w), 0, 0);
        end

        // Client 2 owns; client 1 strobes are discarded; stray sent in GRANT ignored; stall ends packet
        add("c2_idle", 1, 4'h4, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        add("c2_stray", 1, 4'h4, 4'h2, 4'h0, 4'h0, bt(1, 8'hAA) | bt(2, 8'h5C), 1, 1,
            4'h4, 2, 1, 0, 8'h5C, 0, 0);
        add("c2_put", 1, 4'h4, 4'h6, 4'h0, 4'h0, bt(1, 8'hAA) | bt(2, 8'h5D), 1, 0,
            4'h4, 2, 1, 1, 8'h5D, 0, 0);
        add("c2_stall", 1, 4'h4, 4'h0, 4'h2, 4'h4, bt(1, 8'hAA), 1, 0, 4'h4, 2, 1, 0, 8'h00, 0, 1);
        add("c2_wait", 1, 4'h4, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h4, 2, 1, 0, 8'h00, 0, 0);
        add("c2_sent", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 1, 4'h4, 2, 1, 0, 8'h00, 0, 0);

        // Client 1 abandons mid-packet; next winner from 4'b0101 is 2
        add("c1_idle", 1, 4'h2, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 2, 0, 0, 8'h00, 0, 0);
        add("c1_put", 1, 4'h2, 4'h2, 4'h0, 4'h0, bt(1, 8'h31), 1, 0, 4'h2, 1, 1, 1, 8'h31, 0, 0);
        add("c1_drop", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h2, 1, 1, 0, 8'h00, 0, 0);
        add("c1_after", 1, 4'h5, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 1, 0, 0, 8'h00, 0, 0);
        add("c2_win", 1, 4'h5, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h4, 2, 1, 0, 8'h00, 0, 0);

        // Asynchronous reset mid-GRANT, then client 3; done with req drop goes to WAIT_SENT
        add("arst", 0, 4'h5, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        add("arst_rel", 1, 4'h8, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 0, 0, 0, 8'h00, 0, 0);
        add("c3_grant", 1, 4'h8, 4'h8, 4'h0, 4'h0, bt(3, 8'h42), 1, 0, 4'h8, 3, 1, 1, 8'h42, 0, 0);
        add("c3_done_drop", 1, 4'h0, 4'h0, 4'h8, 4'h0, 32'h0, 1, 0, 4'h8, 3, 1, 0, 8'h00, 1, 0);
        add("c3_wait", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h8, 3, 1, 0, 8'h00, 0, 0);
        add("c3_sent", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 1, 4'h8, 3, 1, 0, 8'h00, 0, 0);
        add("c3_idle", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 3, 0, 0, 8'h00, 0, 0);
        // Lone client 3 may win back-to-back
        add("c3_again", 1, 4'h8, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 3, 0, 0, 8'h00, 0, 0);
        add("c3_again_g", 1, 4'h8, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h8, 3, 1, 0, 8'h00, 0, 0);
        add("c3_again_drop", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h8, 3, 1, 0, 8'h00, 0, 0);
        add("c3_final", 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1, 0, 4'h0, 3, 0, 0, 8'h00, 0, 0);

        reset_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Silent owner: grant one cycle after request (rr_ptr=3 so client 0 wins)
        drive(4'h1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("hold.grant_latency", 32'(bus.ep_grant), 32'h1);
`ifdef USB_IN_ARB_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            check_onehot("tout");
            if (c < 16) begin
                check($sformatf("tout.evt_c%0d", c), 32'(timeout_evt), 32'd0);
            end else if (c == 16) begin
                check("tout.evt_c16",   32'(timeout_evt),       32'd1);
                check("tout.bdone_c16", 32'(bus.buf_data_done), 32'd1);
                check("tout.grant_c16", 32'(bus.ep_grant),      32'h1);
            end else begin
                check("tout.evt_c17",   32'(timeout_evt),       32'd0);
                check("tout.bdone_c17", 32'(bus.buf_data_done), 32'd0);
                check("tout.busy_c17",  32'(busy),              32'd1);
                check("tout.grant_c17", 32'(bus.ep_grant),      32'h1);
            end
        end
        drive(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        check("tout.release_grant", 32'(bus.ep_grant), 32'h0);
`else
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold.grant_c%0d", c), 32'({bus.ep_grant, busy}), 32'h3);
            check($sformatf("hold.evt_c%0d", c), 32'(timeout_evt), 32'd0);
        end
        drive(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("hold.release_grant", 32'(bus.ep_grant), 32'h0);
        check("hold.release_busy",  32'(busy),         32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
